// File: rtl/reduce_pkg.sv
// -----------------------------------------------------------------------------
// reduce_pkg
// Shared definitions for the shared bit-reduction arbiter:
//   - opcode encodings OP_AND..OP_XNOR (6 and 7 are illegal)
//   - reduction family encodings (AND / OR / XOR)
//   - FSM state enum
//   - helpers that map an opcode to its family, output inversion, legality
//     and accumulator seed value
// -----------------------------------------------------------------------------
package reduce_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    localparam logic [1:0] FAM_AND = 2'd0;
    localparam logic [1:0] FAM_OR  = 2'd1;
    localparam logic [1:0] FAM_XOR = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Illegal opcodes fall back to the AND family; their result is discarded.
    function automatic logic [1:0] op_family(input logic [2:0] op);
        logic [1:0] fam;
        case (op)
            OP_AND, OP_NAND: fam = FAM_AND;
            OP_OR,  OP_NOR:  fam = FAM_OR;
            OP_XOR, OP_XNOR: fam = FAM_XOR;
            default:         fam = FAM_AND;
        endcase
        return fam;
    endfunction

    function automatic logic op_invert(input logic [2:0] op);
        logic inv;
        case (op)
            OP_NAND, OP_NOR, OP_XNOR: inv = 1'b1;
            default:                  inv = 1'b0;
        endcase
        return inv;
    endfunction

    function automatic logic op_illegal(input logic [2:0] op);
        return (op > OP_XNOR);
    endfunction

    // AND-family accumulation starts from the identity 1, the others from 0.
    function automatic logic op_acc_seed(input logic [2:0] op);
        return (op_family(op) == FAM_AND);
    endfunction

endpackage

// File: rtl/reduce_arbiter_checker.sv
// -----------------------------------------------------------------------------
// reduce_arbiter_checker
// Protocol properties of reduce_arbiter, observed from its ports.
// Ports: clk, rst and the arbiter outputs/rsp_ready (all inputs here).
// -----------------------------------------------------------------------------
module reduce_arbiter_checker #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input logic             clk,
    input logic             rst,
    input logic [N_REQ-1:0] req_ready,
    input logic             busy,
    input logic             rsp_valid,
    input logic             rsp_ready,
    input logic [ID_W-1:0]  rsp_id,
    input logic             rsp_bit,
    input logic             rsp_err
);

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_ready))
        else $error("reduce_arbiter: req_ready not one-hot-or-zero");

    a_grant_idle_only: assert property (@(posedge clk) disable iff (rst)
        busy |-> (req_ready == '0))
        else $error("reduce_arbiter: grant offered while busy");

    a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
        (rsp_valid && !rsp_ready) |=>
            (rsp_valid && $stable(rsp_bit) && $stable(rsp_id) && $stable(rsp_err)))
        else $error("reduce_arbiter: response changed under backpressure");

    a_err_zero_bit: assert property (@(posedge clk) disable iff (rst)
        rsp_err |-> !rsp_bit)
        else $error("reduce_arbiter: rsp_bit set together with rsp_err");

endmodule

// File: rtl/reduce_chunk.sv
// -----------------------------------------------------------------------------
// reduce_chunk
// Purely combinational reduction of one operand chunk.
// Ports:
//   slice  in  CHUNK  operand bits for the current chunk
//   family in  2      FAM_AND / FAM_OR / FAM_XOR
//   red    out 1      &slice, |slice or ^slice
// -----------------------------------------------------------------------------
module reduce_chunk
    import reduce_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] slice,
    input  logic [1:0]       family,
    output logic             red
);

    // Reduce the chunk with the operator of the selected family
    always_comb begin
        red = 1'b0;
        case (family)
            FAM_AND: red = &slice;
            FAM_OR:  red = |slice;
            FAM_XOR: red = ^slice;
            default: red = 1'b0;
        endcase
    end

endmodule

// File: rtl/reduce_arbiter.sv
// -----------------------------------------------------------------------------
// reduce_arbiter
// Shares one chunked bit-reduction unit among N_REQ requesters. A round-robin
// arbiter grants one request while idle; the latched operand is reduced CHUNK
// bits per cycle (LSB chunk first) and a single 1-bit result is returned on a
// valid/ready response port.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   req_valid   per-requester request valid
//   req_op      per-requester opcode, slice i = [3*i+:3]
//   req_data    per-requester operand, slice i = [W*i+:W]
//   req_ready   one-hot grant, only while idle
//   rsp_valid   result valid, held until rsp_ready
//   rsp_ready   consumer accepts the result
//   rsp_id      requester that owns the result
//   rsp_bit     reduction result
//   rsp_err     opcode was illegal
//   busy        an operation is in progress (not idle)
// -----------------------------------------------------------------------------
module reduce_arbiter
    import reduce_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 32,
    parameter int CHUNK = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [3*N_REQ-1:0]       req_op,
    input  logic [W*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic                     rsp_bit,
    output logic                     rsp_err,
    output logic                     busy
);

    localparam int NCHUNK = W / CHUNK;
    localparam int ID_W   = $clog2(N_REQ);
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);
    localparam logic [ID_W:0]    N_REQ_EXT = (ID_W + 1)'(N_REQ);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [ID_W-1:0]  rr_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic             acc_r;
    logic [2:0]       op_r;
    logic [W-1:0]     data_r;
    logic [ID_W-1:0]  id_r;
    logic             rsp_valid_r;
    logic             rsp_bit_r;
    logic [ID_W-1:0]  rsp_id_r;
    logic             rsp_err_r;

    logic [N_REQ-1:0] grant_s;
    logic [ID_W-1:0]  grant_id_s;
    logic             grant_any_s;
    logic             accept_s;
    logic [2:0]       grant_op_s;
    logic [W-1:0]     grant_data_s;
    logic [ID_W-1:0]  rr_ptr_nxt_s;
    logic [ID_W:0]    cand_sum_s;
    logic [ID_W-1:0]  cand_idx_s;
    logic [CHUNK-1:0] chunk_s;
    logic [1:0]       family_s;
    logic             red_s;
    logic             acc_step_s;
    logic             last_chunk_s;

    // Round-robin search: first valid requester at or after rr_ptr, with wrap
    always_comb begin
        grant_s     = '0;
        grant_id_s  = '0;
        grant_any_s = 1'b0;
        cand_sum_s  = '0;
        cand_idx_s  = '0;
        for (int off = 0; off < N_REQ; off++) begin
            cand_sum_s = {1'b0, rr_ptr_r} + (ID_W + 1)'(off);
            cand_sum_s = (cand_sum_s >= N_REQ_EXT) ? (cand_sum_s - N_REQ_EXT) : cand_sum_s;
            cand_idx_s = cand_sum_s[ID_W-1:0];
            if (!grant_any_s && req_valid[cand_idx_s]) begin
                grant_any_s         = 1'b1;
                grant_id_s          = cand_idx_s;
                grant_s[cand_idx_s] = 1'b1;
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    // Operand/opcode of the current winner and the pointer value after it
    always_comb begin
        grant_op_s   = req_op[3*grant_id_s +: 3];
        grant_data_s = req_data[W*grant_id_s +: W];
        if (grant_id_s == ID_W'(N_REQ - 1)) begin
            rr_ptr_nxt_s = '0;
        end else begin
            rr_ptr_nxt_s = grant_id_s + ID_W'(1);
        end
    end

    // FSM next state; the grant is exposed only while idle
    always_comb begin
        state_nxt_s = state_r;
        req_ready   = '0;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                req_ready   = grant_s;
                accept_s    = grant_any_s;
                state_nxt_s = grant_any_s ? BUSY : IDLE;
            end
            BUSY: begin
                state_nxt_s = last_chunk_s ? DONE : BUSY;
            end
            DONE: begin
                state_nxt_s = rsp_ready ? IDLE : DONE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Select the chunk addressed by the counter and fold it into the accumulator
    always_comb begin
        chunk_s      = data_r[int'(cnt_r)*CHUNK +: CHUNK];
        family_s     = op_family(op_r);
        last_chunk_s = (cnt_r == CNT_LAST);
        case (family_s)
            FAM_AND: acc_step_s = acc_r & red_s;
            FAM_OR:  acc_step_s = acc_r | red_s;
            FAM_XOR: acc_step_s = acc_r ^ red_s;
            default: acc_step_s = acc_r;
        endcase
    end

    reduce_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .slice  (chunk_s),
        .family (family_s),
        .red    (red_s)
    );

    // Operand latch, chunk counter, accumulator and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r    <= '0;
            cnt_r       <= '0;
            acc_r       <= 1'b0;
            op_r        <= 3'd0;
            data_r      <= '0;
            id_r        <= '0;
            rsp_valid_r <= 1'b0;
            rsp_bit_r   <= 1'b0;
            rsp_id_r    <= '0;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r     <= grant_op_s;
                        data_r   <= grant_data_s;
                        id_r     <= grant_id_s;
                        rr_ptr_r <= rr_ptr_nxt_s;
                        cnt_r    <= '0;
                        acc_r    <= op_acc_seed(grant_op_s);
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                BUSY: begin
                    acc_r <= acc_step_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last_chunk_s) begin
                        // The final chunk is folded in here, so use the stepped value.
                        rsp_valid_r <= 1'b1;
                        rsp_id_r    <= id_r;
                        rsp_err_r   <= op_illegal(op_r);
                        rsp_bit_r   <= op_illegal(op_r) ? 1'b0 : (acc_step_s ^ op_invert(op_r));
                    end else begin
                        rsp_valid_r <= rsp_valid_r;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        // rsp_bit and rsp_id deliberately keep their last value.
                        rsp_valid_r <= 1'b0;
                        rsp_err_r   <= 1'b0;
                    end else begin
                        rsp_valid_r <= rsp_valid_r;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Drive response ports straight from their registers
    always_comb begin
        rsp_valid = rsp_valid_r;
        rsp_bit   = rsp_bit_r;
        rsp_id    = rsp_id_r;
        rsp_err   = rsp_err_r;
        busy      = (state_r != IDLE);
    end

    reduce_arbiter_checker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_checker (
        .clk       (clk),
        .rst       (rst),
        .req_ready (req_ready),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_bit   (rsp_bit),
        .rsp_err   (rsp_err)
    );

endmodule

// File: tb/tb_reduce_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reduce_arbiter
// Directed and randomized stimulus for reduce_arbiter (N_REQ=4, W=32, CHUNK=8).
// Expected results come from whole-word reduction operators and a simple
// round-robin pick over the valid mask.
// -----------------------------------------------------------------------------
module tb_reduce_arbiter;

    localparam int N_REQ  = 4;
    localparam int W      = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = W / CHUNK;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [3*N_REQ-1:0]   req_op;
    logic [W*N_REQ-1:0]   req_data;
    logic [N_REQ-1:0]     req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [1:0]           rsp_id;
    logic                 rsp_bit;
    logic                 rsp_err;
    logic                 busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int ptr_m = 0;

    reduce_arbiter #(
        .N_REQ (N_REQ),
        .W     (W),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_bit   (rsp_bit),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {err, bit} straight from the opcode table on the whole word
    function automatic logic [1:0] ref_result(input logic [2:0] op, input logic [W-1:0] d);
        case (op)
            3'd0:    return {1'b0, &d};
            3'd1:    return {1'b0, ~&d};
            3'd2:    return {1'b0, |d};
            3'd3:    return {1'b0, ~|d};
            3'd4:    return {1'b0, ^d};
            3'd5:    return {1'b0, ~^d};
            default: return 2'b10;
        endcase
    endfunction

    function automatic int ref_pick(input logic [N_REQ-1:0] v, input int ptr);
        for (int off = 0; off < N_REQ; off++) begin
            if (v[(ptr + off) % N_REQ]) return (ptr + off) % N_REQ;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] pick_data();
        logic [W-1:0] d;
        case ($urandom_range(0, 3))
            0: d = '0;
            1: d = '1;
            2: begin d = '1; d[$urandom_range(0, W-1)] = 1'b0; end
            default: d = W'($urandom);
        endcase
        return d;
    endfunction

    // One full request: grant, chunk latency, optional backpressure, handshake.
    task automatic do_txn(input int bp, input bit hold, input bit expect_now, output int gcyc);
        int exp_id;
        int waited;
        logic [1:0] exp_r;
        #1;
        exp_id = ref_pick(req_valid, ptr_m);
        waited = 0;
        while (req_ready == '0 && waited < 20) begin
            step();
            #1;
            waited++;
        end
        gcyc = cyc;
        check("grant_onehot", req_ready, 64'(1) << exp_id);
        if (req_ready == '0) return;
        if (expect_now) check("grant_latency", waited, 0);
        check("busy_in_idle", busy, 0);
        exp_r = ref_result(req_op[3*exp_id +: 3], req_data[W*exp_id +: W]);
        ptr_m = (exp_id + 1) % N_REQ;
        rsp_ready = (bp == 0);
        step();
        if (!hold) req_valid[exp_id] = 1'b0;
        req_data[W*exp_id +: W] = ~req_data[W*exp_id +: W] ^ W'($urandom);
        #1;
        check("busy_run", busy, 1);
        check("no_grant_busy", req_ready, 0);
        repeat (NCHUNK - 1) step();
        check("rsp_early", rsp_valid, 0);
        step();
        check("rsp_valid", rsp_valid, 1);
        check("rsp_bit", rsp_bit, exp_r[0]);
        check("rsp_id", rsp_id, exp_id);
        check("rsp_err", rsp_err, exp_r[1]);
        for (int k = 0; k < bp; k++) begin
            step();
            check("bp_valid", rsp_valid, 1);
            check("bp_bit", rsp_bit, exp_r[0]);
            check("bp_id", rsp_id, exp_id);
            check("bp_err", rsp_err, exp_r[1]);
            check("bp_no_grant", req_ready, 0);
        end
        rsp_ready = 1'b1;
        step();
        check("post_valid", rsp_valid, 0);
        check("post_err", rsp_err, 0);
        check("post_bit_hold", rsp_bit, exp_r[0]);
        check("post_id_hold", rsp_id, exp_id);
        check("post_busy", busy, 0);
    endtask

    initial begin
        int g;
        int g_prev;
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_bit", rsp_bit, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_err", rsp_err, 0);
        rst = 1'b0;
        step();
        check("idle_no_req", req_ready, 0);
        ptr_m = 0;

        // T1: AND of all ones on requester 0
        req_op[2:0]     = 3'd0;
        req_data[31:0]  = 32'hFFFF_FFFF;
        req_valid       = 4'b0001;
        do_txn(0, 1'b0, 1'b1, g);

        // T2: NOR 0 -> 1, XNOR 1 -> 0, XOR 7 -> 1 on requester 1
        req_op[5:3] = 3'd3; req_data[63:32] = 32'h0000_0000; req_valid = 4'b0010;
        do_txn(0, 1'b0, 1'b1, g);
        req_op[5:3] = 3'd5; req_data[63:32] = 32'h0000_0001; req_valid = 4'b0010;
        do_txn(0, 1'b0, 1'b1, g);
        req_op[5:3] = 3'd4; req_data[63:32] = 32'h0000_0007; req_valid = 4'b0010;
        do_txn(0, 1'b0, 1'b1, g);

        // T3: after a reset in idle, all requesters held valid -> 0,1,2,3,0
        rst = 1'b1;
        step();
        rst = 1'b0;
        ptr_m = 0;
        for (int i = 0; i < N_REQ; i++) begin
            req_op[3*i +: 3]  = 3'($urandom_range(0, 5));
            req_data[W*i +: W] = pick_data();
        end
        req_valid = 4'b1111;
        do_txn(0, 1'b1, 1'b1, g_prev);
        for (int n = 0; n < 4; n++) begin
            do_txn(0, 1'b1, 1'b1, g);
            check("grant_spacing", g - g_prev, NCHUNK + 2);
            g_prev = g;
        end
        req_valid = '0;

        // T4: backpressure for 3 cycles while requester 0 waits
        req_op[11:9] = 3'd2; req_data[127:96] = 32'h0010_0000;
        req_op[2:0]  = 3'd0; req_data[31:0]   = 32'hFFFF_FFFF;
        req_valid = 4'b1001;
        do_txn(3, 1'b0, 1'b1, g);
        do_txn(0, 1'b0, 1'b1, g);

        // T5: illegal opcode on requester 2, then a legal request clears rsp_err
        req_op[8:6] = 3'd6; req_data[95:64] = 32'hFFFF_FFFF; req_valid = 4'b0100;
        do_txn(0, 1'b0, 1'b1, g);
        req_op[5:3] = 3'd0; req_data[63:32] = 32'hFFFF_FFFF; req_valid = 4'b0010;
        do_txn(0, 1'b0, 1'b1, g);

        // T6: reset during BUSY cycle 2 abandons the operation
        req_op[8:6] = 3'd2; req_data[95:64] = 32'h0000_0100; req_valid = 4'b0100;
        #1;
        check("t6_grant", req_ready, 4'b0100);
        step();
        req_valid = '0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        ptr_m = 0;
        check("t6_busy", busy, 0);
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_rsp_bit", rsp_bit, 0);
        check("t6_rsp_id", rsp_id, 0);
        check("t6_rsp_err", rsp_err, 0);
        repeat (NCHUNK + 2) step();
        check("t6_no_rsp", rsp_valid, 0);
        req_op[5:3]  = 3'd4; req_data[63:32]  = 32'h0000_0003;
        req_op[11:9] = 3'd4; req_data[127:96] = 32'h0000_0001;
        req_valid = 4'b1010;
        do_txn(0, 1'b0, 1'b1, g);

        // Randomized masks, opcodes (including illegal), operands and backpressure
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N_REQ; i++) begin
                req_op[3*i +: 3]   = 3'($urandom_range(0, 7));
                req_data[W*i +: W] = pick_data();
            end
            req_valid = 4'($urandom_range(1, 15));
            do_txn($urandom_range(0, 2), 1'b0, 1'b1, g);
        end

        req_valid = '0;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
